muldiv_unit: RTL and testbench
==============================

Name: muldiv_unit

Overview:
- Multi-cycle integer multiply/divide execute unit for the RV32M extension.
- Sits beside the single-cycle ALU in the execute stage; the decode stage steers M-extension ops here.
- Uses a valid/ready handshake on both sides, so the pipeline stalls while an op is in flight.
- Carries a destination tag so writeback can route the result.

Parameters:
- WIDTH, 32, operand/result width in bits; must be even and >= 8.
- TAG_W, 5, width of the destination-register tag carried with each op.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- flush  input  1  abort the in-flight op and discard any pending result.
- in_valid  input  1  request valid.
- in_ready  output  1  unit can accept a request.
- in0  input  WIDTH  rs1 operand (dividend / multiplicand).
- in1  input  WIDTH  rs2 operand (divisor / multiplier).
- op  input  3  0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- in_tag  input  TAG_W  destination tag.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- out  output  WIDTH  result.
- out_tag  output  TAG_W  tag of the result.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- States:
  - IDLE: in_ready=1.
  - CALC: iterating.
  - DONE: out_valid=1.
- Reset (rst=1 at an edge):
  - state becomes IDLE; out_valid=0, out=0, out_tag=0, busy=0, internal counter=0.
  - rst overrides flush and all handshakes, including mid-operation.
- Accept:
  - A request is accepted on an edge where state=IDLE and in_valid=1.
  - Operands, op and tag are registered at that edge.
  - in_ready is a pure function of state (IDLE), never of in_valid.
- Signed handling:
  - Operands are converted to magnitudes at accept:
    - in0 is signed for MULH, MULHSU, DIV, REM.
    - in1 is signed for MULH, DIV, REM.
  - The unsigned core result is negated at completion when the sign rule requires it:
    - product sign = XOR of the operand signs;
    - quotient sign = XOR of the operand signs;
    - remainder sign = dividend sign.
- Multiply:
  - Radix-2 shift-add over a 2*WIDTH accumulator; one multiplier bit per cycle, WIDTH cycles in CALC.
  - MUL returns the low WIDTH bits; MULH, MULHSU and MULHU return the high WIDTH bits.
- Divide:
  - Restoring division, one quotient bit per cycle, WIDTH cycles in CALC.
  - DIV/DIVU return the quotient; REM/REMU return the remainder.
- Special cases (decided at accept, bypass CALC, go straight to DONE):
  - Divide by zero: quotient = all ones; remainder = in0.
  - Signed overflow (in0 = most-negative value, in1 = all ones, DIV/REM only): quotient = in0; remainder = 0.
- Latency:
  - Normal op: accept at edge 0, CALC for edges 1..WIDTH, out_valid=1 after edge WIDTH+1.
  - Special case: out_valid=1 after edge 1.
- DONE:
  - out and out_tag are held stable while out_valid=1 and out_ready=0.
  - Result leaves on an edge with out_ready=1; state returns to IDLE, out_valid=0.
  - The next accept is possible on the following edge; no same-edge complete+accept.
- Flush:
  - In CALC or DONE, flush=1 at an edge returns the state to IDLE with out_valid=0; the result is lost.
  - In IDLE, flush blocks acceptance on that edge.
  - flush and a completing out handshake on the same edge: flush wins; the consumer must ignore the result.
- Counter:
  - Width is clog2(WIDTH)+1; it counts down from WIDTH and leaves CALC at 0.
  - No wrap-around is possible.

Optional Feature:
- Macro: MULDIV_FAST_MUL_EN.
- Defined:
  - MUL, MULH, MULHSU and MULHU use a single combinational WIDTH x WIDTH product computed on registered magnitudes.
  - They bypass CALC and go straight to DONE, so out_valid=1 after edge 1.
  - Divide behaviour is unchanged.
- Undefined:
  - The iterative shift-add path is used, with WIDTH-cycle latency.
  - No multiplier array is inferred.

Test Plan:
- MUL, in0=7, in1=-3 (0xFFFFFFFD), out_ready=1 -> out=0xFFFFFFEB (-21), out_valid exactly 33 cycles after accept (1 with MULDIV_FAST_MUL_EN).
- MULH, 0x80000000 x 0x80000000 -> out=0x40000000; MULHU, 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULHSU, 0xFFFFFFFF x 2 -> 0xFFFFFFFF.
- DIV, -7 / 2 -> out=-3 (0xFFFFFFFD); REM, -7 % 2 -> -1 (0xFFFFFFFF); DIVU, 100 / 7 -> 14; REMU -> 2.
- DIVU, 5 / 0 -> out=0xFFFFFFFF after 1 cycle; REM, 5 % 0 -> 5; DIV, 0x80000000 / 0xFFFFFFFF -> 0x80000000 and REM -> 0, both after 1 cycle.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid -> out and out_tag stable, in_ready=0 throughout; raise out_ready -> in_ready=1 on the next cycle and a back-to-back request is accepted.
- Flush at cycle 10 of a DIVU -> out_valid never asserts, in_ready=1 on the next cycle; then rst asserted mid-CALC of another op -> all outputs reset values next cycle.

Source files
------------

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - Multi-cycle RV32M multiply/divide execute unit
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   flush                         abort in-flight op / discard pending result
//   in_valid, in_ready            request handshake
//   in0, in1, op, in_tag          operands, M-extension opcode, destination tag
//   out_valid, out_ready          result handshake
//   out, out_tag                  result and its destination tag
//   busy                          high whenever the unit is not idle
//
// Optional feature macro: MULDIV_FAST_MUL_EN
//   defined   - multiplies use one combinational WIDTH x WIDTH product
//   undefined - multiplies use the iterative shift-add path

module muldiv_unit #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    input  logic [2:0]       op,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_nx;

    // acc: multiply -> {partial product high, multiplier shifting out}
    //      divide   -> {partial remainder, dividend/quotient bits}
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   mreg;      // multiplicand or divisor magnitude
    logic [2:0]         op_r;
    logic [TAG_W-1:0]   tag_r;
    logic               neg_r;     // negate the core result at completion
    logic [CW-1:0]      cnt;

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid && !flush) state_nx = CALC;
            end
            CALC: begin
                if (flush)            state_nx = IDLE;
                else if (cnt == '0)   state_nx = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (flush || out_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // ---------------- accept-side decode ----------------
    logic             s0, s1, div_zero, div_ovf, neg_in;
    logic [WIDTH-1:0] mag0, mag1;

    always_comb begin
        s0       = ((op == 3'd1) || (op == 3'd2) || (op == 3'd4) || (op == 3'd6)) && in0[WIDTH-1];
        s1       = ((op == 3'd1) || (op == 3'd4) || (op == 3'd6)) && in1[WIDTH-1];
        mag0     = s0 ? -in0 : in0;
        mag1     = s1 ? -in1 : in1;
        div_zero = op[2] && (in1 == '0);
        div_ovf  = ((op == 3'd4) || (op == 3'd6)) &&
                   (in0 == {1'b1, {(WIDTH-1){1'b0}}}) && (in1 == '1);
        // Remainder follows the dividend; products and quotients use the XOR.
        neg_in   = (op == 3'd6) ? s0 : (s0 ^ s1);
    end

    // ---------------- iteration step ----------------
    logic [WIDTH:0]     mul_sum, div_rs, div_diff;
    logic               div_ge;
    logic [2*WIDTH-1:0] acc_step;

    always_comb begin
        mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? mreg : {WIDTH{1'b0}})};
        div_rs   = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        div_diff = div_rs - {1'b0, mreg};
        div_ge   = !div_diff[WIDTH];
        if (op_r[2])
            acc_step = {(div_ge ? div_diff[WIDTH-1:0] : div_rs[WIDTH-1:0]),
                        acc[WIDTH-2:0], div_ge};
        else
            acc_step = {mul_sum, acc[WIDTH-1:1]};
    end

    // ---------------- completion ----------------
    logic [2*WIDTH-1:0] core, mul_full;
    logic [WIDTH-1:0]   div_sel, result;

    always_comb begin
`ifdef MULDIV_FAST_MUL_EN
        core = op_r[2] ? acc
                       : ({{WIDTH{1'b0}}, acc[WIDTH-1:0]} * {{WIDTH{1'b0}}, mreg});
`else
        core = acc;
`endif
        mul_full = neg_r ? -core : core;
        div_sel  = ((op_r == 3'd4) || (op_r == 3'd5)) ? core[WIDTH-1:0]
                                                      : core[2*WIDTH-1:WIDTH];
        if (op_r[2])
            result = neg_r ? -div_sel : div_sel;
        else if (op_r == 3'd0)
            result = mul_full[WIDTH-1:0];
        else
            result = mul_full[2*WIDTH-1:WIDTH];
    end

    // ---------------- datapath ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            acc     <= '0;
            mreg    <= '0;
            op_r    <= '0;
            tag_r   <= '0;
            neg_r   <= 1'b0;
            cnt     <= '0;
            out     <= '0;
            out_tag <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && !flush) begin
                        op_r  <= op;
                        tag_r <= in_tag;
                        neg_r <= neg_in;
                        cnt   <= CW'(WIDTH);
                        if (div_zero) begin
                            // Raw values already are the final answer: no negation.
                            acc   <= {in0, {WIDTH{1'b1}}};
                            neg_r <= 1'b0;
                            cnt   <= '0;
                        end else if (div_ovf) begin
                            acc   <= {{WIDTH{1'b0}}, in0};
                            neg_r <= 1'b0;
                            cnt   <= '0;
                        end else if (op[2]) begin
                            acc  <= {{WIDTH{1'b0}}, mag0};
                            mreg <= mag1;
                        end else begin
                            acc  <= {{WIDTH{1'b0}}, mag1};
                            mreg <= mag0;
`ifdef MULDIV_FAST_MUL_EN
                            cnt  <= '0;
`endif
                        end
                    end
                end
                CALC: begin
                    if (cnt != '0) begin
                        acc <= acc_step;
                        cnt <= cnt - 1'b1;
                    end else begin
                        out     <= result;
                        out_tag <= tag_r;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - Self-checking bench for muldiv_unit

module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, in_ready, out_valid, out_ready, busy;
    logic [31:0] in0, in1, out;
    logic [2:0]  op;
    logic [4:0]  in_tag, out_tag;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    muldiv_unit #(.WIDTH(32), .TAG_W(5)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in0(in0), .in1(in1), .op(op), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out(out), .out_tag(out_tag), .busy(busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference behaviour straight from the RV32M definitions.
    function automatic logic [31:0] ref_model(input logic [2:0] o, input logic [31:0] a,
                                               input logic [31:0] b);
        longint      sa, sb, ua, ub;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'b0, a});
        ub = longint'({32'b0, b});
        p  = '0;
        case (o)
            3'd0: begin p = sa * sb; return p[31:0];  end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                p = sa / sb; return p[31:0];
            end
            3'd5: begin
                if (b == 0) return 32'hFFFF_FFFF;
                p = ua / ub; return p[31:0];
            end
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                p = sa % sb; return p[31:0];
            end
            default: begin
                if (b == 0) return a;
                p = ua % ub; return p[31:0];
            end
        endcase
    endfunction

    function automatic int exp_lat(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        if (o >= 3'd4 && b == 0) return 1;
        if ((o == 3'd4 || o == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
`ifdef MULDIV_FAST_MUL_EN
        if (o < 3'd4) return 1;
`endif
        return 33;
    endfunction

    // Issue one op (caller sits #1 after an edge), wait for out_valid and
    // check the latency. Leaves the caller #1 after the edge where out_valid rose.
    task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] t, output logic [31:0] r, output logic [4:0] rt);
        int w = 0;
        int n = 0;
        while (!in_ready && w < 100) begin @(posedge clk); #1; w++; end
        check("in_ready_before_accept", {31'b0, in_ready}, 32'd1);
        op = o; in0 = a; in1 = b; in_tag = t; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        while (!out_valid && n < 100) begin @(posedge clk); #1; n++; end
        check("latency", n, exp_lat(o, a, b));
        r  = out;
        rt = out_tag;
    endtask

    logic [2:0]  d_op  [12] = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd4, 3'd6, 3'd5, 3'd7, 3'd5, 3'd6, 3'd4, 3'd6};
    logic [31:0] d_a   [12] = '{32'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                                32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100,
                                32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
    logic [31:0] d_b   [12] = '{32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF, 32'd2,
                                32'd2, 32'd2, 32'd7, 32'd7,
                                32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] d_exp [12] = '{32'hFFFF_FFEB, 32'h4000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF,
                                32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14, 32'd2,
                                32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0};

    initial begin
        logic [31:0] r, a, b;
        logic [4:0]  rt, t;
        logic [2:0]  o;
        bit          seen;

        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in0 = '0; in1 = '0; op = '0; in_tag = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_out_valid", {31'b0, out_valid}, 32'd0);
        check("reset_out", out, 32'd0);
        check("reset_out_tag", {27'b0, out_tag}, 32'd0);
        check("reset_busy", {31'b0, busy}, 32'd0);
        check("reset_in_ready", {31'b0, in_ready}, 32'd1);
        rst = 1'b0;
        @(posedge clk); #1;

        // Flush while idle blocks the accept.
        in_valid = 1'b1; flush = 1'b1; op = 3'd5; in0 = 32'd9; in1 = 32'd3;
        @(posedge clk); #1;
        in_valid = 1'b0; flush = 1'b0;
        check("idle_flush_blocks_accept", {31'b0, busy}, 32'd0);

        // Directed cases.
        for (int i = 0; i < 12; i++) begin
            t = 5'(i + 1);
            run_op(d_op[i], d_a[i], d_b[i], t, r, rt);
            check($sformatf("directed_%0d_out", i), r, d_exp[i]);
            check($sformatf("directed_%0d_tag", i), {27'b0, rt}, {27'b0, t});
            @(posedge clk); #1;
            check($sformatf("directed_%0d_release", i), {30'b0, out_valid, in_ready}, 32'd1);
        end

        // Backpressure: result and tag held, no new accept while DONE.
        out_ready = 1'b0;
        run_op(3'd5, 32'd1000, 32'd3, 5'd9, r, rt);
        check("bp_first_out", r, 32'd333);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check("bp_hold_out", out, 32'd333);
            check("bp_hold_tag", {27'b0, out_tag}, 32'd9);
            check("bp_hold_flags", {30'b0, out_valid, in_ready}, 32'd2);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_release", {30'b0, out_valid, in_ready}, 32'd1);
        run_op(3'd7, 32'd1000, 32'd7, 5'd10, r, rt);
        check("bp_back_to_back_out", r, 32'd6);
        check("bp_back_to_back_tag", {27'b0, rt}, 32'd10);
        @(posedge clk); #1;

        // Randomized ops against the reference model.
        for (int i = 0; i < 150; i++) begin
            o = 3'($urandom_range(0, 7));
            a = $urandom; b = $urandom;
            case ($urandom_range(0, 7))
                0: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                1: b = 32'd0;
                2: b = 32'($urandom_range(1, 15));
                3: a = 32'hFFFF_FFFF;
                default: ;
            endcase
            t = 5'($urandom);
            run_op(o, a, b, t, r, rt);
            check($sformatf("rand_op%0d_%h_%h", o, a, b), r, ref_model(o, a, b));
            check("rand_tag", {27'b0, rt}, {27'b0, t});
            @(posedge clk); #1;
        end

        // Flush on the 10th edge of a DIVU: result never appears.
        op = 3'd5; in0 = 32'd12345; in1 = 32'd11; in_tag = 5'd17; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush_in_ready", {31'b0, in_ready}, 32'd1);
        check("flush_busy", {31'b0, busy}, 32'd0);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (out_valid) seen = 1'b1;
            @(posedge clk); #1;
        end
        check("flush_no_out_valid", {31'b0, seen}, 32'd0);

        // Reset in the middle of CALC.
        op = 3'd0; in0 = 32'd1234; in1 = 32'd5678; in_tag = 5'd21; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("pre_rst_busy", {31'b0, busy}, 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midrst_out_valid", {31'b0, out_valid}, 32'd0);
        check("midrst_out", out, 32'd0);
        check("midrst_out_tag", {27'b0, out_tag}, 32'd0);
        check("midrst_busy", {31'b0, busy}, 32'd0);
        check("midrst_in_ready", {31'b0, in_ready}, 32'd1);

        // Unit still works after reset.
        run_op(3'd4, 32'hFFFF_FF9C, 32'd7, 5'd3, r, rt);
        check("post_rst_div", r, 32'hFFFF_FFF2);
        @(posedge clk); #1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
